// File: rtl/fpga1_self_checker_if.sv
// Sample and check-result bundle between the fpga1 cell tap and its self-checker.
// Handshake: in_valid marks a sample; no back-pressure, so the checker accepts every valid cycle.
interface fpga1_self_checker_if #(
   parameter int CNT_W = 8
);
   logic             clear;
   logic             in_valid;
   logic             a;
   logic             b;
   logic             c;
   logic             d;
   logic             e;
   logic             e_n;
   logic             out_valid;
   logic             err_func;
   logic             err_rail;
   logic             err_now;
   logic             fault_transient;
   logic             fault_perm;
   logic [1:0]       state;
   logic [CNT_W-1:0] err_count;

   modport master (
      output clear, in_valid, a, b, c, d, e, e_n,
      input  out_valid, err_func, err_rail, err_now,
      input  fault_transient, fault_perm, state, err_count
   );

   modport slave (
      input  clear, in_valid, a, b, c, d, e, e_n,
      output out_valid, err_func, err_rail, err_now,
      output fault_transient, fault_perm, state, err_count
   );
endinterface

// File: rtl/fpga1_self_checker.sv
// Golden-table and two-rail checker for the fpga1 cell, with transient/permanent
// fault classification and a saturating error counter.
module fpga1_self_checker #(
   parameter logic [15:0] TRUTH       = 16'h6996,
   parameter int          PERM_THRESH = 3,
   parameter int          CNT_W       = 8
) (
   input logic                 clk,
   input logic                 rst,
   fpga1_self_checker_if.slave chk
);
   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_SUSPECT = 2'b01,
      ST_FAULT   = 2'b10,
      ST_UNUSED  = 2'b11
   } state_t;

   localparam logic [3:0] THRESH = 4'(PERM_THRESH);

   state_t           state_q;
   logic [3:0]       consec_q;
   logic             out_valid_q;
   logic             err_func_q;
   logic             err_rail_q;
   logic             err_now_q;
   logic             fault_transient_q;
   logic [CNT_W-1:0] err_count_q;

   logic [3:0] idx;
   logic       golden;
   logic       func_bad;
   logic       rail_bad;
   logic       err_in;
   logic       sample;

   always_comb begin
      idx      = {chk.a, chk.b, chk.c, chk.d};
      golden   = TRUTH[idx];
      func_bad = chk.e != golden;
      rail_bad = chk.e == chk.e_n;
      err_in   = func_bad | rail_bad;
      sample   = chk.in_valid;
   end

   always_ff @(posedge clk) begin
      if (rst || chk.clear) begin
         state_q           <= ST_OK;
         consec_q          <= 4'd0;
         out_valid_q       <= 1'b0;
         err_func_q        <= 1'b0;
         err_rail_q        <= 1'b0;
         err_now_q         <= 1'b0;
         fault_transient_q <= 1'b0;
         err_count_q       <= '0;
      end else begin
         out_valid_q <= sample;
         err_func_q  <= sample & func_bad;
         err_rail_q  <= sample & rail_bad;
         err_now_q   <= sample & err_in;

         if (sample && err_in && (err_count_q != {CNT_W{1'b1}}))
            err_count_q <= err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};

         // Idle cycles hold the FSM so a burst is counted over valid samples only.
         case (state_q)
            ST_OK: begin
               if (sample && err_in) begin
                  if (THRESH == 4'd1) begin
                     state_q <= ST_FAULT;
                  end else begin
                     state_q  <= ST_SUSPECT;
                     consec_q <= 4'd1;
                  end
               end
            end
            ST_SUSPECT: begin
               if (sample) begin
                  if (err_in) begin
                     consec_q <= consec_q + 4'd1;
                     if (consec_q + 4'd1 == THRESH)
                        state_q <= ST_FAULT;
                  end else begin
                     state_q           <= ST_OK;
                     consec_q          <= 4'd0;
                     fault_transient_q <= 1'b1;
                  end
               end
            end
            ST_FAULT: state_q <= ST_FAULT;
            default: begin
               state_q  <= ST_OK;
               consec_q <= 4'd0;
            end
         endcase
      end
   end

   assign chk.out_valid       = out_valid_q;
   assign chk.err_func        = err_func_q;
   assign chk.err_rail        = err_rail_q;
   assign chk.err_now         = err_now_q;
   assign chk.fault_transient = fault_transient_q;
   assign chk.fault_perm      = (state_q == ST_FAULT);
   assign chk.state           = state_q;
   assign chk.err_count       = err_count_q;
endmodule

// File: tb/tb_fpga1_self_checker.sv
// Directed bench for fpga1_self_checker: main instance (CNT_W=8, PERM_THRESH=3) and a
// small instance (CNT_W=2, PERM_THRESH=1) for saturation and single-error fault entry.
module tb_fpga1_self_checker;
   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;
   int   n_fail;

   fpga1_self_checker_if #(.CNT_W(8)) m_if ();
   fpga1_self_checker_if #(.CNT_W(2)) s_if ();

   fpga1_self_checker #(.TRUTH(16'h6996), .PERM_THRESH(3), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .chk(m_if.slave)
   );

   fpga1_self_checker #(.TRUTH(16'h6996), .PERM_THRESH(1), .CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .chk(s_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] abcd, input logic ev, input logic env,
                        input logic clr);
      m_if.in_valid = v;
      {m_if.a, m_if.b, m_if.c, m_if.d} = abcd;
      m_if.e     = ev;
      m_if.e_n   = env;
      m_if.clear = clr;
   endtask

   task automatic drive_small(input logic v, input logic [3:0] abcd, input logic ev,
                              input logic env);
      s_if.in_valid = v;
      {s_if.a, s_if.b, s_if.c, s_if.d} = abcd;
      s_if.e     = ev;
      s_if.e_n   = env;
      s_if.clear = 1'b0;
   endtask

   // Advance one edge and settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_flags(input string tag, input logic ov, input logic ef, input logic er,
                            input logic [1:0] st, input logic ft, input logic [7:0] cnt);
      chk({tag, ".out_valid"}, 32'(m_if.out_valid), 32'(ov));
      chk({tag, ".err_func"}, 32'(m_if.err_func), 32'(ef));
      chk({tag, ".err_rail"}, 32'(m_if.err_rail), 32'(er));
      chk({tag, ".err_now"}, 32'(m_if.err_now), 32'(ef | er));
      chk({tag, ".state"}, 32'(m_if.state), 32'(st));
      chk({tag, ".fault_perm"}, 32'(m_if.fault_perm), 32'(st == 2'b10));
      chk({tag, ".fault_transient"}, 32'(m_if.fault_transient), 32'(ft));
      chk({tag, ".err_count"}, 32'(m_if.err_count), 32'(cnt));
   endtask

   logic [3:0] sweep [7];

   initial begin
      n_total = 0;
      n_pass  = 0;
      n_fail  = 0;
      sweep = '{4'b0000, 4'b1100, 4'b1101, 4'b0101, 4'b0001, 4'b1001, 4'b1111};

      // Reset held with garbage samples presented.
      rst = 1'b1;
      drive(1'b1, 4'b1010, 1'b1, 1'b1, 1'b0);
      drive_small(1'b1, 4'b0111, 1'b0, 1'b0);
      tick();
      tick();
      chk_flags("reset", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
      chk("reset.small_count", 32'(s_if.err_count), 32'd0);
      chk("reset.small_state", 32'(s_if.state), 32'd0);
      rst = 1'b0;
      drive(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
      drive_small(1'b0, 4'b0000, 1'b0, 1'b1);
      tick();
      chk_flags("idle", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);

      // Fault-free sweep, back-to-back; e is the parity of abcd.
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, sweep[i], ^sweep[i], ~(^sweep[i]), 1'b0);
         tick();
         chk_flags($sformatf("sweep%0d", i), 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
      end
      drive(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
      tick();
      chk("sweep_end.out_valid", 32'(m_if.out_valid), 32'd0);

      // Single functional error then a good sample: transient burst.
      drive(1'b1, 4'b1101, 1'b0, 1'b1, 1'b0);
      tick();
      chk_flags("trans_err", 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 8'd1);
      drive(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0);
      tick();
      chk_flags("trans_ok", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 8'd1);
      // Rail violation with a correct functional value.
      drive(1'b1, 4'b0001, 1'b1, 1'b1, 1'b0);
      tick();
      chk_flags("rail_err", 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 8'd2);
      drive(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0);
      tick();
      chk_flags("rail_ok", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 8'd2);

      // Permanent fault: three errors on 0101 (golden 0), idle gap before the third.
      drive(1'b1, 4'b0101, 1'b1, 1'b0, 1'b0);
      tick();
      chk_flags("perm1", 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'd3);
      tick();
      chk_flags("perm2", 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'd4);
      drive(1'b0, 4'b0101, 1'b1, 1'b0, 1'b0);
      tick();
      chk_flags("perm_gap", 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'd4);
      drive(1'b1, 4'b0101, 1'b1, 1'b0, 1'b0);
      tick();
      chk_flags("perm3", 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 8'd5);
      // Good samples do not leave FAULT; transient flag stays set.
      drive(1'b1, 4'b1100, 1'b0, 1'b1, 1'b0);
      tick();
      chk_flags("fault_hold1", 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 8'd5);
      drive(1'b1, 4'b1000, 1'b1, 1'b0, 1'b0);
      tick();
      chk_flags("fault_hold2", 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 8'd5);

      // Clear together with an erroneous sample: sample discarded, everything zeroed.
      drive(1'b1, 4'b0101, 1'b1, 1'b1, 1'b1);
      tick();
      chk_flags("clear", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
      drive(1'b1, 4'b0111, 1'b1, 1'b0, 1'b0);
      tick();
      chk_flags("after_clear", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
      drive(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);

      // Small instance: first error goes straight to FAULT; counter holds at 3.
      for (int i = 0; i < 5; i++) begin
         drive_small(1'b1, 4'b0000, 1'b1, 1'b0);
         tick();
         chk($sformatf("small%0d.state", i), 32'(s_if.state), 32'd2);
         chk($sformatf("small%0d.fault_perm", i), 32'(s_if.fault_perm), 32'd1);
         chk($sformatf("small%0d.err_count", i), 32'(s_if.err_count), (i < 3) ? i + 1 : 3);
      end
      drive_small(1'b0, 4'b0000, 1'b0, 1'b1);
      tick();
      chk("small_end.out_valid", 32'(s_if.out_valid), 32'd0);
      chk("small_end.err_count", 32'(s_if.err_count), 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
